// File: rtl/i2c_slave_at24c02.sv
// AT24C02-style 256-byte EEPROM responder on the two-wire bus.
// Oversamples scl/sda on the system clock and never stretches the clock.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | bus free or STOP seen, sda released
// S_DEV_ADDR | shifting the 8-bit device address + R/W after START
// S_DEV_ACK  | driving ACK for a matched device address
// S_REG_ADDR | shifting the register (pointer) address
// S_REG_ACK  | driving ACK for the register address
// S_WR_DATA  | shifting a write data byte
// S_WR_ACK   | byte committed, driving ACK
// S_RD_DATA  | driving read data bits, MSB first
// S_RD_ACK   | sda released, sampling the master ACK/NACK
// S_IGNORE   | not addressed or read ended, wait for START/STOP
module i2c_slave_at24c02 #(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       sys_clk_12m,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [7:0] at24c02_00_data
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_REG_ADDR, S_REG_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    localparam logic [2:0] FILT_TC = 3'(FILT_LEN - 1);

    logic [1:0] scl_sync, sda_sync;
    logic       scl_f, sda_f, scl_d, sda_d;
    logic [2:0] scl_cnt, sda_cnt;
    logic       scl_rise, scl_fall, start_det, stop_det;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] ptr;
    logic       rw;
    logic       m_ack;
    logic       sda_oe;
    logic       shift_in, byte_done;
    logic [7:0] mem [256];
    logic [7:0] rd_byte;

    // Open-drain pad: only ever pull low or release.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Two-flop synchronizers; the bus idles high.
    always_ff @(posedge sys_clk_12m or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
        end
    end

    // Level filters: a level changes only after FILT_LEN identical opposite samples.
    always_ff @(posedge sys_clk_12m or posedge rst) begin
        if (rst) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_d   <= 1'b1;
            sda_d   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FILT_TC) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 3'd1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FILT_TC) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 3'd1;
            end
        end
    end

    // scl must be high in both cycles so a simultaneous scl/sda move is not a condition.
    assign scl_rise  =  scl_f & ~scl_d;
    assign scl_fall  = ~scl_f &  scl_d;
    assign start_det = ~sda_f &  sda_d & scl_f & scl_d;
    assign stop_det  =  sda_f & ~sda_d & scl_f & scl_d;
    assign shift_in  = scl_rise && (bit_cnt != 4'd8);
    assign byte_done = scl_fall && (bit_cnt == 4'd8);
    assign rd_byte   = mem[ptr];

    // Storage is deliberately not reset; the commit strobe writes it one cycle later.
    always_ff @(posedge sys_clk_12m) begin
        if (wr_valid) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Protocol FSM; START/STOP override any bit activity in the same cycle.
    always_ff @(posedge sys_clk_12m or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            bit_cnt         <= '0;
            shreg           <= '0;
            ptr             <= '0;
            rw              <= 1'b0;
            m_ack           <= 1'b0;
            sda_oe          <= 1'b0;
            busy            <= 1'b0;
            wr_valid        <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            at24c02_00_data <= '0;
        end else begin
            wr_valid <= 1'b0;
            if (start_det) begin
                state   <= S_DEV_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= S_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    S_DEV_ADDR: begin
                        if (shift_in) begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (byte_done) begin
                            bit_cnt <= '0;
                            if (shreg[7:1] == DEV_ADDR) begin
                                state  <= S_DEV_ACK;
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= shreg[0];
                            end else begin
                                state <= S_IGNORE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    S_DEV_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                state  <= S_RD_DATA;
                                shreg  <= rd_byte;
                                sda_oe <= ~rd_byte[7];
                            end else begin
                                state  <= S_REG_ADDR;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    S_REG_ADDR: begin
                        if (shift_in) begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (byte_done) begin
                            bit_cnt <= '0;
                            ptr     <= shreg;
                            state   <= S_REG_ACK;
                            sda_oe  <= 1'b1;
                        end
                    end
                    S_REG_ACK, S_WR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            state   <= S_WR_DATA;
                            sda_oe  <= 1'b0;
                        end
                    end
                    S_WR_DATA: begin
                        if (shift_in) begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (byte_done) begin
                            bit_cnt  <= '0;
                            wr_valid <= 1'b1;
                            wr_addr  <= ptr;
                            wr_data  <= shreg;
                            if (ptr == 8'h00) begin
                                at24c02_00_data <= shreg;
                            end
                            ptr    <= ptr + 8'd1;
                            sda_oe <= 1'b1;
                            state  <= S_WR_ACK;
                        end
                    end
                    S_RD_DATA: begin
                        if (shift_in) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= '0;
                                sda_oe  <= 1'b0;
                                state   <= S_RD_ACK;
                            end else begin
                                sda_oe <= ~shreg[3'(4'd7 - bit_cnt)];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        // bit_cnt doubles as "ninth rise seen" so the decision waits for the fall.
                        if (scl_rise) begin
                            m_ack   <= ~sda_f;
                            ptr     <= ptr + 8'd1;
                            bit_cnt <= 4'd1;
                        end else if (scl_fall && (bit_cnt != 4'd0)) begin
                            bit_cnt <= '0;
                            if (m_ack) begin
                                state  <= S_RD_DATA;
                                shreg  <= rd_byte;
                                sda_oe <= ~rd_byte[7];
                            end else begin
                                state <= S_IGNORE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    S_IDLE, S_IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_at24c02.sv
// Bench for the AT24C02-style responder: a bus-master driver, a byte-level
// EEPROM model, and scoreboard monitors for write strobes and bus responses.
module tb_i2c_slave_at24c02;

    localparam int         Q   = 10;
    localparam logic [6:0] DEV = 7'h50;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_low;
    wire        sda;
    logic       wr_valid;
    logic [7:0] wr_addr, wr_data, at00;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mdl_mem [256];
    bit         mdl_known [256];
    logic [7:0] mdl_ptr;
    logic [7:0] mdl_00;
    logic [7:0] wbuf [8];

    logic [15:0] exp_wr [$];
    int          exp_bus [$];
    string       exp_name [$];
    int          act_bus [$];

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave_at24c02 #(.DEV_ADDR(DEV), .FILT_LEN(3)) dut (
        .sys_clk_12m    (clk),
        .rst            (rst),
        .scl            (scl),
        .sda            (sda),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy           (busy),
        .at24c02_00_data(at00)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_bus(input string nm, input int v);
        exp_bus.push_back(v);
        exp_name.push_back(nm);
    endtask

    // Write-strobe monitor.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wr_valid) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
                end else begin
                    logic [15:0] e;
                    e = exp_wr.pop_front();
                    check("wr_addr", wr_addr, e[15:8]);
                    check("wr_data", wr_data, e[7:0]);
                    if (e[15:8] == 8'h00) check("at00_live", at00, e[7:0]);
                end
            end
        end
    end

    // Bus-response monitor: ACK bits and read bytes seen by the master.
    initial begin
        forever begin
            @(negedge clk);
            while (act_bus.size() > 0) begin
                int a;
                a = act_bus.pop_front();
                if (exp_bus.size() == 0) begin
                    n_checks++;
                    $display("FAIL bus_unexpected: got 0x%0h expected nothing", a);
                end else begin
                    check(exp_name.pop_front(), a, exp_bus.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    task automatic bus_start();
        m_low = 1'b0; wait_clk(Q);
        scl = 1'b1;   wait_clk(Q);
        m_low = 1'b1; wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(Q); m_low = 1'b1; wait_clk(Q);
        scl = 1'b1;  wait_clk(Q);
        m_low = 1'b0; wait_clk(Q);
    endtask

    // One bit with scl low at entry; g=1 glitches scl low, g=2 glitches sda, during scl high.
    task automatic bit_xfer(input logic b, input int g, output logic rx);
        wait_clk(Q); m_low = ~b;
        wait_clk(Q); scl = 1'b1;
        wait_clk(8);
        if (g == 1) scl = 1'b0;
        if (g == 2) m_low = ~m_low;
        wait_clk(2);
        if (g == 1) scl = 1'b1;
        if (g == 2) m_low = ~m_low;
        wait_clk(4);
        rx = sda;
        wait_clk(6);
        scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, input int gbit, input int gkind, output logic ack);
        logic rx;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], (i == gbit) ? gkind : 0, rx);
        bit_xfer(1'b1, 0, rx);
        ack = ~rx;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic rx;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, 0, rx);
            d = {d[6:0], rx};
        end
        bit_xfer(~master_ack, 0, rx);
    endtask

    // Write transaction: device address, register, n bytes from wbuf.
    task automatic txn_write(input logic [6:0] dev, input logic [7:0] reg_a, input int n,
                             input int gbit, input int gkind);
        logic ack;
        int   match;
        match = (dev == DEV) ? 1 : 0;
        bus_start();
        expect_bus("ack_dev_w", match);
        write_byte({dev, 1'b0}, -1, 0, ack);
        act_bus.push_back(int'(ack));
        check("busy_addressed", busy, match);
        expect_bus("ack_reg", match);
        write_byte(reg_a, -1, 0, ack);
        act_bus.push_back(int'(ack));
        if (match == 1) mdl_ptr = reg_a;
        for (int i = 0; i < n; i++) begin
            expect_bus("ack_data", match);
            if (match == 1) begin
                exp_wr.push_back({mdl_ptr, wbuf[i]});
                mdl_mem[mdl_ptr]   = wbuf[i];
                mdl_known[mdl_ptr] = 1'b1;
                if (mdl_ptr == 8'h00) mdl_00 = wbuf[i];
                mdl_ptr = mdl_ptr + 8'd1;
            end
            write_byte(wbuf[i], (i == 0) ? gbit : -1, gkind, ack);
            act_bus.push_back(int'(ack));
        end
        if (gkind != 0) check("busy_after_glitch", busy, match);
        bus_stop();
    endtask

    // Read: optional pointer set + repeated START, then n bytes, last one NACKed.
    task automatic txn_read(input bit set_ptr, input logic [7:0] reg_a, input int n);
        logic       ack;
        logic [7:0] d;
        bus_start();
        if (set_ptr) begin
            expect_bus("ack_dev_w", 1);
            write_byte({DEV, 1'b0}, -1, 0, ack);
            act_bus.push_back(int'(ack));
            expect_bus("ack_reg", 1);
            write_byte(reg_a, -1, 0, ack);
            act_bus.push_back(int'(ack));
            mdl_ptr = reg_a;
            bus_start();
        end
        expect_bus("ack_dev_r", 1);
        write_byte({DEV, 1'b1}, -1, 0, ack);
        act_bus.push_back(int'(ack));
        for (int i = 0; i < n; i++) begin
            if (!mdl_known[mdl_ptr]) $display("note: reading unwritten address 0x%0h", mdl_ptr);
            expect_bus("rd_data", int'(mdl_mem[mdl_ptr]));
            mdl_ptr = mdl_ptr + 8'd1;
            read_byte(i != n - 1, d);
            act_bus.push_back(int'(d));
        end
        wait_clk(Q);
        check("sda_released_after_nack", sda, 1);
        bus_stop();
        wait_clk(2);
        check("busy_after_stop", busy, 0);
    endtask

    initial begin
        logic       ack, rx;
        logic [7:0] rbyte;
        int         n, rn;
        logic [7:0] ra;

        for (int i = 0; i < 256; i++) mdl_known[i] = 1'b0;
        mdl_ptr = 8'h00;
        mdl_00  = 8'h00;
        rst = 1'b1; scl = 1'b1; m_low = 1'b0;
        wait_clk(4);
        check("rst_sda", sda, 1);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_at00", at00, 0);
        rst = 1'b0;
        wait_clk(2 * Q);

        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        txn_write(DEV, 8'h10, 2, -1, 0);

        txn_read(1'b1, 8'h10, 2);

        wbuf[0] = 8'hFF;
        txn_write(7'h51, 8'h00, 1, -1, 0);
        check("sda_idle_after_mismatch", sda, 1);

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        txn_write(DEV, 8'hFF, 2, -1, 0);
        check("at00_after_wrap", at00, mdl_00);

        wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
        txn_write(DEV, 8'h30, 2, int'($urandom_range(0, 7)), 1);
        wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
        txn_write(DEV, 8'h40, 2, int'($urandom_range(0, 7)), 2);
        txn_read(1'b1, 8'h30, 2);

        // Reset during the register-address ACK bit.
        bus_start();
        expect_bus("ack_dev_w", 1);
        write_byte({DEV, 1'b0}, -1, 0, ack);
        act_bus.push_back(int'(ack));
        rbyte = 8'h40;
        for (int i = 7; i >= 0; i--) bit_xfer(rbyte[i], 0, rx);
        wait_clk(Q); m_low = 1'b0;
        wait_clk(Q); scl = 1'b1;
        wait_clk(4);
        check("ack_before_rst", sda, 0);
        rst = 1'b1;
        #1;
        check("rst_mid_sda", sda, 1);
        check("rst_mid_wr_valid", wr_valid, 0);
        check("rst_mid_wr_addr", wr_addr, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_at00", at00, 0);
        mdl_ptr = 8'h00;
        mdl_00  = 8'h00;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2 * Q);
        txn_read(1'b0, 8'h00, 1);
        check("at00_after_rst", at00, mdl_00);

        for (int it = 0; it < 6; it++) begin
            ra = 8'($urandom);
            n  = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
            txn_write(DEV, ra, n, -1, 0);
            rn = int'($urandom_range(1, n));
            txn_read(1'b1, ra, rn);
        end
        check("at00_final", at00, mdl_00);

        wait_clk(20);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("bus_queue_drained", exp_bus.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
